// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one memory request at a time and
// loads the Fetch/Decode register, handling decode stalls and execute-stage redirects.
module fetch_ctrl #(
    parameter int unsigned       XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PCsrcE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic            StallD,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] PCF,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
);

    localparam logic [XLEN-1:0] INSTR_BYTES = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK  = ~XLEN'(3);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DROP
    } state_t;

    state_t          state;
    logic [XLEN-1:0] hold_data;
    logic [XLEN-1:0] hold_pc;
    logic [XLEN-1:0] pc_next;
    logic            can_load;

    assign pc_next   = PCF + INSTR_BYTES;
    assign can_load  = !ValidD || !StallD;
    assign imem_req  = (state == REQ);
    assign imem_addr = PCF;

    // A redirect pre-empts all other activity; a request still in flight forces DROP
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            PCF       <= RESET_PC;
            InstrD    <= '0;
            PCD       <= '0;
            PCPlus4D  <= '0;
            ValidD    <= 1'b0;
            hold_data <= '0;
            hold_pc   <= '0;
        end else if (PCsrcE) begin
            PCF       <= PCTargetE & ALIGN_MASK;
            ValidD    <= 1'b0;
            hold_data <= '0;
            hold_pc   <= '0;
            case (state)
                REQ, DROP: state <= DROP;
                WAIT:      state <= imem_rvalid ? REQ : DROP;
                default:   state <= REQ;
            endcase
        end else begin
            // Decode consumes a live instruction; a load below overrides this
            if (ValidD && !StallD) begin
                ValidD <= 1'b0;
            end
            case (state)
                IDLE: state <= REQ;
                REQ:  state <= WAIT;
                WAIT: begin
                    if (imem_rvalid) begin
                        if (can_load) begin
                            InstrD   <= imem_rdata;
                            PCD      <= PCF;
                            PCPlus4D <= pc_next;
                            ValidD   <= 1'b1;
                            PCF      <= pc_next;
                            state    <= REQ;
                        end else begin
                            hold_data <= imem_rdata;
                            hold_pc   <= PCF;
                            state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!StallD) begin
                        InstrD   <= hold_data;
                        PCD      <= hold_pc;
                        PCPlus4D <= hold_pc + INSTR_BYTES;
                        ValidD   <= 1'b1;
                        PCF      <= pc_next;
                        state    <= REQ;
                    end
                end
                DROP: begin
                    if (imem_rvalid) begin
                        state <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequences the instruction-fetch stage of the pipelined RISC-V core when instruction memory has variable latency. Owns the PC and issues one request at a time. Delivers fetched words into the Fetch/Decode pipeline register (InstrD/PCD/PCPlus4D). Applies decode stalls (StallD) and execute-stage redirects (PCsrcE/PCTargetE), and discards in-flight responses made stale by a redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
XLEN, 32, address/instruction width (only 32 supported).

Ports:
clk  in  1  single clock; all state changes on rising edge.
rst  in  1  asynchronous, active-low reset.
PCsrcE  in  1  redirect request from execute stage.
PCTargetE  in  32  redirect target address.
StallD  in  1  decode stage cannot accept a new instruction this cycle.
imem_req  out  1  request strobe to instruction memory; one-cycle pulse.
imem_addr  out  32  request address; equals PCF while imem_req=1.
imem_rvalid  in  1  response valid; at most one per request, ≥1 cycle after imem_req.
imem_rdata  in  32  response data, valid with imem_rvalid.
PCF  out  32  current fetch PC.
InstrD  out  32  decode-register instruction.
PCD  out  32  decode-register PC.
PCPlus4D  out  32  decode-register PC+4.
ValidD  out  1  decode register holds a live instruction.

Behaviour:
- Reset (rst=0, asynchronous, any state): PCF=RESET_PC; InstrD=PCD=PCPlus4D=0; ValidD=0; hold buffer cleared; state=IDLE; imem_req=0.
- Outputs: imem_req=(state==REQ), combinational. imem_addr=PCF.
- States: IDLE, REQ, WAIT, HOLD, DROP.
- IDLE: next cycle → REQ. First request is issued in the second cycle after reset release.
- REQ: issue the request; → WAIT.
- WAIT with imem_rvalid=1:
  - If the decode register can load (ValidD=0 or StallD=0): InstrD=rdata, PCD=PCF, PCPlus4D=PCF+4, ValidD=1, PCF=PCF+4; → REQ.
  - Otherwise, capture rdata and PCF into the hold buffer; → HOLD.
- HOLD: no requests issued. When StallD=0, transfer the hold buffer to the decode register (ValidD=1) and set PCF=PCF+4; → REQ.
- Consumption: if ValidD=1, StallD=0 and nothing loads this cycle, ValidD → 0. InstrD, PCD and PCPlus4D keep their values.
- Redirect (PCsrcE=1) has priority over everything except reset, and overrides StallD.
  - PCF=PCTargetE with bits[1:0] forced to 00.
  - ValidD=0 (flush decode register). Hold buffer discarded.
  - Next state from REQ, or from WAIT with rvalid=0: DROP (response still outstanding).
  - Next state from WAIT with rvalid=1, HOLD, or IDLE: REQ.
  - From DROP: stay in DROP. PCF still updates to the new target.
- DROP: the next imem_rvalid is discarded without loading anything; → REQ.
- imem_rvalid in IDLE, REQ or HOLD is ignored.
- Arithmetic: PC+4 is modulo 2^32; 0xFFFFFFFC wraps to 0.
- Latency: for memory latency L (rvalid L cycles after the req cycle), ValidD rises at the edge where rvalid is sampled. Peak throughput is one instruction per L+1 cycles.
- At most one outstanding request at any time.

Test Plan:
1. Reset: assert rst=0 while in WAIT. Required: outputs cleared immediately (async), PCF=0. After release, imem_req=1 with addr 0 in the 2nd cycle; a late rvalid arriving before that request is ignored.
2. Straight line, L=1: word 0x00500093 at addr 0, word 0x00A00113 at addr 4. Required: InstrD=0x00500093, PCD=0, PCPlus4D=4, ValidD=1. Then InstrD=0x00A00113, PCD=4, PCPlus4D=8. Next request addr=8.
3. Stall: hold StallD=1 with ValidD=1 while the word for addr 4 returns. Required: state HOLD, no imem_req, InstrD unchanged. On StallD=0: InstrD=word@4, PCD=4, then next request addr 8.
4. Redirect in WAIT: PCsrcE=1 with PCTargetE=0x100, one cycle before rvalid. Required: ValidD=0, PCF=0x100, the returning word is dropped, next request addr 0x100.
5. Redirect coincident with rvalid and StallD=1: target 0x103. Required: redirect wins, response dropped, ValidD=0, next request addr 0x100.
6. Wrap: RESET_PC=0xFFFFFFFC. Required: first fetch gives PCD=0xFFFFFFFC, PCPlus4D=0; next request addr 0.
